// File: rtl/instr_fetch.sv
// instr_fetch: two-stage fetch unit with PC, branch/skip flush and circular return stack
module instr_fetch #(
    parameter int STACK_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [9:0]  PM_ADDR,
    input  logic [13:0] PM_DATA,
    input  logic        HOLD,
    input  logic        SKIP,
    input  logic        PCL_WR,
    input  logic [7:0]  PCL_DATA,
    input  logic [4:0]  PCLATH,
    output logic [13:0] OP_CODE,
    output logic        OP_VALID,
    output logic [12:0] PC,
    output logic        STACK_OVF,
    output logic        STACK_UNF
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(STACK_DEPTH);

    logic [12:0]   stack [STACK_DEPTH];
    logic [PW-1:0] ptr, ptr_dec;
    logic [PW:0]   depth;
    logic          is_goto, is_call, is_ret, flush, push, pop;
    logic [12:0]   pc_nxt, top;

    assign PM_ADDR = PC[9:0];

    // decode the executing opcode and pick the next PC by priority: PCL write, branch/return, skip/sequential
    always_comb begin
        ptr_dec = ptr - 1'b1;
        top     = stack[ptr_dec];
        is_goto = OP_VALID && (OP_CODE[13:11] == 3'b101);
        is_call = OP_VALID && (OP_CODE[13:11] == 3'b100);
        is_ret  = OP_VALID && ((OP_CODE == 14'h0008) || (OP_CODE == 14'h0009) || (OP_CODE[13:10] == 4'b1101));
        push    = !HOLD && !PCL_WR && is_call;
        pop     = !HOLD && !PCL_WR && is_ret;
        flush   = PCL_WR || is_goto || is_call || is_ret || SKIP;
        pc_nxt  = PCL_WR              ? {PCLATH, PCL_DATA} :
                  (is_goto || is_call) ? {PCLATH[4:3], OP_CODE[10:0]} :
                  is_ret               ? top : PC + 13'd1;
    end

    // pipeline registers, stack pointer/depth and sticky flags; HOLD freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC        <= '0;
            OP_CODE   <= '0;
            OP_VALID  <= 1'b0;
            ptr       <= '0;
            depth     <= '0;
            STACK_OVF <= 1'b0;
            STACK_UNF <= 1'b0;
        end else if (!HOLD) begin
            PC       <= pc_nxt;
            OP_CODE  <= flush ? 14'h0000 : PM_DATA;
            OP_VALID <= !flush;
            if (push) begin
                ptr <= ptr + 1'b1;
                if (depth == FULL) STACK_OVF <= 1'b1;
                else depth <= depth + 1'b1;
            end
            if (pop) begin
                ptr <= ptr_dec;
                if (depth == '0) STACK_UNF <= 1'b1;
                else depth <= depth - 1'b1;
            end
        end
    end

    // return-address storage; contents need no reset, at full depth the oldest slot is overwritten
    always_ff @(posedge clk) begin
        if (push) stack[ptr] <= PC;
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenario bench for instr_fetch
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  pm_addr;
    logic [13:0] pm_data;
    logic        hold = 1'b0, skip = 1'b0, pcl_wr = 1'b0;
    logic [7:0]  pcl_data = '0;
    logic [4:0]  pclath = '0;
    logic [13:0] op_code;
    logic        op_valid;
    logic [12:0] pc;
    logic        stack_ovf, stack_unf;
    logic [13:0] pm [1024];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign pm_data = pm[pm_addr];

    instr_fetch #(.STACK_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .PM_ADDR(pm_addr), .PM_DATA(pm_data),
        .HOLD(hold), .SKIP(skip), .PCL_WR(pcl_wr), .PCL_DATA(pcl_data), .PCLATH(pclath),
        .OP_CODE(op_code), .OP_VALID(op_valid), .PC(pc),
        .STACK_OVF(stack_ovf), .STACK_UNF(stack_unf)
    );

    // non-branch filler: 0x3000 | address
    task automatic fill_pm();
        for (int i = 0; i < 1024; i++) pm[i] = 14'h3000 | 14'(i);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hold = 1'b0; skip = 1'b0; pcl_wr = 1'b0; pcl_data = '0; pclath = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        fill_pm();
        pm[0] = 14'h30A3; pm[1] = 14'h3E15;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 13'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc); end
        checks++; if (op_code !== 14'h0 || op_valid !== 1'b0) begin errors++; $display("FAIL rst_op got %h/%b want 0000/0", op_code, op_valid); end
        checks++; if (stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b want 00", stack_ovf, stack_unf); end
        do_reset();
        tick();
        checks++; if (op_code !== 14'h30A3 || op_valid !== 1'b1 || pc !== 13'd1) begin errors++; $display("FAIL first_fetch got %h/%b/%h want 30a3/1/0001", op_code, op_valid, pc); end
        tick();
        checks++; if (op_code !== 14'h3E15 || pc !== 13'd2) begin errors++; $display("FAIL second_fetch got %h/%h want 3e15/0002", op_code, pc); end
        checks++; if (pm_addr !== 10'd2) begin errors++; $display("FAIL pm_addr got %h want 002", pm_addr); end
    endtask

    task automatic test_goto();
        fill_pm();
        pm[2] = 14'h2805;
        do_reset();
        repeat (3) tick();
        checks++; if (op_code !== 14'h2805 || pc !== 13'd3) begin errors++; $display("FAIL goto_fetch got %h/%h want 2805/0003", op_code, pc); end
        tick();
        checks++; if (op_code !== 14'h0 || op_valid !== 1'b0 || pc !== 13'd5) begin errors++; $display("FAIL goto_flush got %h/%b/%h want 0000/0/0005", op_code, op_valid, pc); end
        tick();
        checks++; if (op_code !== 14'h3005 || op_valid !== 1'b1 || pc !== 13'd6) begin errors++; $display("FAIL goto_target got %h/%b/%h want 3005/1/0006", op_code, op_valid, pc); end
    endtask

    task automatic test_call_return();
        fill_pm();
        pm[3] = 14'h2010; pm[16] = 14'h0008;
        do_reset();
        repeat (4) tick();
        checks++; if (op_code !== 14'h2010 || pc !== 13'd4) begin errors++; $display("FAIL call_fetch got %h/%h want 2010/0004", op_code, pc); end
        tick();
        checks++; if (pc !== 13'h10 || op_valid !== 1'b0) begin errors++; $display("FAIL call_pc got %h/%b want 0010/0", pc, op_valid); end
        checks++; if (dut.depth !== 4'd1 || dut.stack[0] !== 13'd4) begin errors++; $display("FAIL call_push depth %0d top %h want 1/0004", dut.depth, dut.stack[0]); end
        tick();
        checks++; if (op_code !== 14'h0008 || pc !== 13'h11) begin errors++; $display("FAIL ret_fetch got %h/%h want 0008/0011", op_code, pc); end
        tick();
        checks++; if (pc !== 13'd4 || op_code !== 14'h0 || dut.depth !== 4'd0) begin errors++; $display("FAIL ret_pop got pc %h op %h depth %0d want 0004/0000/0", pc, op_code, dut.depth); end
        tick();
        checks++; if (op_code !== 14'h3004 || pc !== 13'd5 || stack_unf !== 1'b0) begin errors++; $display("FAIL ret_resume got %h/%h/%b want 3004/0005/0", op_code, pc, stack_unf); end
    endtask

    task automatic test_skip();
        fill_pm();
        pm[5] = 14'h0B8C;
        do_reset();
        repeat (6) tick();
        checks++; if (op_code !== 14'h0B8C || pc !== 13'd6) begin errors++; $display("FAIL skip_fetch got %h/%h want 0b8c/0006", op_code, pc); end
        skip = 1'b1;
        tick();
        skip = 1'b0;
        checks++; if (op_code !== 14'h0 || op_valid !== 1'b0 || pc !== 13'd7) begin errors++; $display("FAIL skip_flush got %h/%b/%h want 0000/0/0007", op_code, op_valid, pc); end
        tick();
        checks++; if (op_code !== 14'h3007 || op_valid !== 1'b1 || pc !== 13'd8) begin errors++; $display("FAIL skip_next got %h/%b/%h want 3007/1/0008", op_code, op_valid, pc); end
    endtask

    task automatic test_pcl_wr();
        fill_pm();
        pm[0] = 14'h2805;
        do_reset();
        tick();
        pcl_wr = 1'b1; pcl_data = 8'h34; pclath = 5'h12;
        tick();
        pcl_wr = 1'b0;
        checks++; if (pc !== 13'h1234 || op_valid !== 1'b0 || pm_addr !== 10'h234) begin errors++; $display("FAIL pcl_prio got %h/%b/%h want 1234/0/234", pc, op_valid, pm_addr); end
        tick();
        checks++; if (op_code !== 14'h3234 || pc !== 13'h1235) begin errors++; $display("FAIL pcl_fetch got %h/%h want 3234/1235", op_code, pc); end
        pcl_wr = 1'b1; pcl_data = 8'hFF; pclath = 5'h1F;
        tick();
        pcl_wr = 1'b0;
        checks++; if (pc !== 13'h1FFF) begin errors++; $display("FAIL pcl_max got %h want 1fff", pc); end
        tick();
        checks++; if (pc !== 13'h0 || op_code !== 14'h33FF) begin errors++; $display("FAIL pc_wrap got %h/%h want 0000/33ff", pc, op_code); end
        tick();
        tick();
        checks++; if (pc !== 13'h1805) begin errors++; $display("FAIL goto_page got %h want 1805", pc); end
    endtask

    task automatic test_stack_ovf_unf();
        fill_pm();
        pm[0] = 14'h2000; pm[1] = 14'h0008;
        do_reset();
        tick();
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++; if (dut.depth !== 4'((i > 8) ? 8 : i) || stack_ovf !== (i == 9)) begin errors++; $display("FAIL push%0d depth %0d ovf %b want %0d/%b", i, dut.depth, stack_ovf, (i > 8) ? 8 : i, i == 9); end
            if (i == 9) pm[0] = 14'h0008;
            tick();
        end
        for (int j = 1; j <= 9; j++) begin
            tick();
            checks++; if (dut.depth !== 4'((j > 8) ? 0 : 8 - j) || stack_unf !== (j == 9) || pc !== 13'd1) begin errors++; $display("FAIL pop%0d depth %0d unf %b pc %h want %0d/%b/0001", j, dut.depth, stack_unf, pc, (j > 8) ? 0 : 8 - j, j == 9); end
            tick();
        end
        checks++; if (stack_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", stack_ovf); end
    endtask

    task automatic test_hold();
        fill_pm();
        do_reset();
        repeat (3) tick();
        hold = 1'b1; skip = 1'b1; pcl_wr = 1'b1; pcl_data = 8'hAA;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (pc !== 13'd3 || op_code !== 14'h3002 || op_valid !== 1'b1) begin errors++; $display("FAIL hold%0d got %h/%h/%b want 0003/3002/1", k, pc, op_code, op_valid); end
        end
        hold = 1'b0; skip = 1'b0; pcl_wr = 1'b0;
        tick();
        checks++; if (op_code !== 14'h3003 || pc !== 13'd4) begin errors++; $display("FAIL hold_release got %h/%h want 3003/0004", op_code, pc); end
    endtask

    task automatic test_reset_mid_flush();
        fill_pm();
        pm[2] = 14'h2805;
        do_reset();
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 13'h0 || op_code !== 14'h0 || op_valid !== 1'b0 || pm_addr !== 10'h0) begin errors++; $display("FAIL async_rst got %h/%h/%b want 0000/0000/0", pc, op_code, op_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (op_code !== 14'h3000 || op_valid !== 1'b1 || pc !== 13'd1) begin errors++; $display("FAIL restart got %h/%b/%h want 3000/1/0001", op_code, op_valid, pc); end
    endtask

    initial begin
        test_reset();
        test_goto();
        test_call_return();
        test_skip();
        test_pcl_wr();
        test_stack_ovf_unf();
        test_hold();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
